// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters with a registered valid/ready response
module alu_arbiter #(
   parameter int NBITS  = 8,
   parameter int COD_OP = 6,
   parameter int NCNT   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [NBITS-1:0]  req0_a,
   input  logic [NBITS-1:0]  req0_b,
   input  logic [COD_OP-1:0] req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [NBITS-1:0]  req1_a,
   input  logic [NBITS-1:0]  req1_b,
   input  logic [COD_OP-1:0] req1_op,
   output logic [NBITS-1:0]  alu_a,
   output logic [NBITS-1:0]  alu_b,
   output logic [COD_OP-1:0] alu_op,
   input  logic [NBITS-1:0]  alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [NBITS-1:0]  rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [NCNT-1:0]   op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state_q, state_d;
   logic last_q, last_d, id_q, id_d, err_q, err_d;
   logic [NBITS-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
   logic [COD_OP-1:0] op_q, op_d;
   logic [NCNT-1:0] cnt_q, cnt_d;
   logic gnt_any, gnt_id, legal;
   always_comb begin
      gnt_any = req0_valid | req1_valid;
      // on a tie the port that did not win last time goes next
      gnt_id = (req0_valid & req1_valid) ? ~last_q : req1_valid;
      legal = op_q inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b100110, 6'b000011, 6'b000010, 6'b100111};
      state_d = state_q;
      last_d = last_q;
      id_d = id_q;
      err_d = err_q;
      a_d = a_q;
      b_d = b_q;
      op_d = op_q;
      data_d = data_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (gnt_any) begin
            a_d = gnt_id ? req1_a : req0_a;
            b_d = gnt_id ? req1_b : req0_b;
            op_d = gnt_id ? req1_op : req0_op;
            id_d = gnt_id;
            last_d = gnt_id;
            state_d = EXEC;
         end
         EXEC: begin
            data_d = alu_result;
            err_d = ~legal;
            state_d = RESP;
         end
         default: if (rsp_ready) begin
            cnt_d = cnt_q + 1'b1;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q <= 1'b1;
         id_q <= 1'b0;
         err_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         data_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         id_q <= id_d;
         err_q <= err_d;
         a_q <= a_d;
         b_q <= b_d;
         op_q <= op_d;
         data_q <= data_d;
         cnt_q <= cnt_d;
      end
   end
   assign req0_ready = (state_q == IDLE) & req0_valid & ~gnt_id;
   assign req1_ready = (state_q == IDLE) & req1_valid & gnt_id;
   assign alu_a = a_q;
   assign alu_b = b_q;
   assign alu_op = op_q;
   assign rsp_valid = state_q == RESP;
   assign rsp_id = id_q;
   assign rsp_data = data_q;
   assign rsp_err = err_q;
   assign busy = state_q != IDLE;
   assign op_count = cnt_q;
endmodule
